// File: rtl/flow_isa_pkg.sv
// flow_isa_pkg: opcodes, request kinds and encoder states shared by the encoder and the decoder side.
package flow_isa_pkg;
    localparam logic [3:0] OPC_NULL  = 4'h0;
    localparam logic [3:0] OPC_UNARY = 4'hD;
    localparam logic [3:0] OPC_INC   = 4'hE;
    localparam logic [3:0] OPC_JUMP  = 4'hF;

    typedef enum logic [1:0] {
        KIND_NULL   = 2'd0,
        KIND_BINARY = 2'd1,
        KIND_INC    = 2'd2,
        KIND_JUMP   = 2'd3
    } kind_e;

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN} enc_state_e;

    // Opcodes owned by non-binary formats; a binary word carrying one would decode as something else.
    function automatic logic reserved_op(input logic [3:0] op);
        return op == OPC_NULL || op == OPC_UNARY || op == OPC_INC || op == OPC_JUMP;
    endfunction
endpackage

// File: rtl/instruction_encoder_fifo.sv
// instruction_encoder_fifo: small synchronous FIFO; a push while full is taken when a pop frees a slot that cycle.
module instruction_encoder_fifo #(
    parameter int W = 16,
    parameter int D = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic [W-1:0]         din,
    input  logic                 pop,
    output logic [W-1:0]         dout,
    output logic                 full,
    output logic                 empty,
    output logic [$clog2(D):0]   level
);
    localparam int AW = $clog2(D);

    logic [W-1:0]  mem_q [D];
    logic [W-1:0]  mem_d [D];
    logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [AW:0]   lvl_q, lvl_d;
    logic          do_push, do_pop;

    always_comb begin
        do_pop  = pop && lvl_q != '0;
        do_push = push && (lvl_q != (AW+1)'(D) || do_pop);
        mem_d   = mem_q;
        if (do_push) mem_d[wr_q] = din;
        wr_d  = wr_q + AW'(do_push);
        rd_d  = rd_q + AW'(do_pop);
        lvl_d = lvl_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < D; i++) mem_q[i] <= '0;
            rd_q  <= '0;
            wr_q  <= '0;
            lvl_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            lvl_q <= lvl_d;
        end
    end

    assign dout  = mem_q[rd_q];
    assign full  = lvl_q == (AW+1)'(D);
    assign empty = lvl_q == '0;
    assign level = lvl_q;
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: packs field requests into 16-bit words and streams them into instruction memory.
// Optional INSTRUCTION_ENCODER_RANGE_CHECK_EN drops binary requests using a reserved opcode and sets err.
module instruction_encoder
    import flow_isa_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  base_addr,
    input  logic        finish,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_kind,
    input  logic [3:0]  in_op,
    input  logic [3:0]  in_a,
    input  logic [3:0]  in_b,
    input  logic [3:0]  in_out,
    input  logic [7:0]  in_imm,
    input  logic [11:0] in_jump,
    output logic        imem_we,
    output logic [7:0]  imem_addr,
    output logic [15:0] imem_wdata,
    output logic        busy,
    output logic        done,
    output logic [8:0]  count,
    output logic        err
);
    enc_state_e  state_q, state_d;
    logic [7:0]  ptr_q, ptr_d, addr_q, addr_d;
    logic [8:0]  count_q, count_d;
    logic [15:0] wdata_q, wdata_d, enc_word, head;
    logic        we_q, we_d, done_q, done_d, err_q, err_d;
    logic        accept, drop, pop, full, empty;
    logic [2:0]  level;

    // Words still in the FIFO are already committed, so they count against the 256-word session limit.
    assign in_ready = state_q == ST_LOAD && !full && ({1'b0, count_q} + 10'(level)) < 10'd256;
    assign accept   = in_valid && in_ready;
    assign pop      = !empty;

`ifdef INSTRUCTION_ENCODER_RANGE_CHECK_EN
    assign drop = in_kind == KIND_BINARY && reserved_op(in_op);
`else
    assign drop = 1'b0;
`endif

    assign enc_word = in_kind == KIND_BINARY ? {in_op, in_a, in_b, in_out}
                    : in_kind == KIND_INC    ? {OPC_INC, in_imm, in_out}
                    : {in_kind == KIND_JUMP ? OPC_JUMP : OPC_NULL, in_jump};

    instruction_encoder_fifo #(.W(16), .D(4)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (accept && !drop),
        .din   (enc_word),
        .pop   (pop),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .level (level)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q + 8'(pop);
        count_d = (pop && count_q != 9'd256) ? count_q + 9'd1 : count_q;
        we_d    = pop;
        addr_d  = pop ? ptr_q : addr_q;
        wdata_d = pop ? head : wdata_q;
        done_d  = 1'b0;
        err_d   = err_q || (accept && drop);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
                    ptr_d   = base_addr;
                    count_d = '0;
                end
            end
            ST_LOAD:  if (finish) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (empty) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            count_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            count_q <= count_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign imem_we    = we_q;
    assign imem_addr  = addr_q;
    assign imem_wdata = wdata_q;
    assign busy       = state_q != ST_IDLE;
    assign done       = done_q;
    assign count      = count_q;
    assign err        = err_q;
endmodule
